// File: rtl/vga_pixel_requester_if.sv
// vga_pixel_requester_if: drawer coordinate/colour handshake plus DAC-side pins
interface vga_pixel_requester_if;
  logic [10:0] oCoord_X;
  logic [10:0] oCoord_Y;
  logic        frame_start;
  logic        drawing_request;
  logic [7:0]  mVGA_RGB;
  logic [7:0]  VGA_R;
  logic [7:0]  VGA_G;
  logic [7:0]  VGA_B;
  logic        VGA_HS;
  logic        VGA_VS;
  logic        VGA_BLANK_N;
  modport master (
    output oCoord_X, oCoord_Y, frame_start, VGA_R, VGA_G, VGA_B, VGA_HS, VGA_VS, VGA_BLANK_N,
    input  drawing_request, mVGA_RGB
  );
  modport slave (
    input  oCoord_X, oCoord_Y, frame_start, VGA_R, VGA_G, VGA_B, VGA_HS, VGA_VS, VGA_BLANK_N,
    output drawing_request, mVGA_RGB
  );
endinterface

// File: rtl/vga_pixel_requester.sv
// vga_pixel_requester: raster timing, coordinate issue to drawers, and registered DAC pins
module vga_pixel_requester #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP = 16,
  parameter int H_SYNC = 96,
  parameter int H_BP = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP = 10,
  parameter int V_SYNC = 2,
  parameter int V_BP = 33,
  parameter int DRAW_LATENCY = 1,
  parameter logic [7:0] BG_COLOR = 8'h00
) (
  input logic CLK,
  input logic RESET,
  vga_pixel_requester_if.master bus
);
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  logic [10:0] h_cnt, v_cnt;
  logic h_wrap, v_wrap, active, hs_n, vs_n;
  logic [DRAW_LATENCY-1:0] active_d, hs_d, vs_d;
  logic [7:0] color;
  assign h_wrap = h_cnt == 11'(H_TOTAL - 1);
  assign v_wrap = v_cnt == 11'(V_TOTAL - 1);
  assign bus.oCoord_X = h_cnt;
  assign bus.oCoord_Y = v_cnt;
  assign bus.frame_start = h_cnt == 11'd0 && v_cnt == 11'd0 && !RESET;
  always_ff @(posedge CLK) begin
    if (RESET) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else begin
      h_cnt <= h_wrap ? '0 : h_cnt + 11'd1;
      if (h_wrap) v_cnt <= v_wrap ? '0 : v_cnt + 11'd1;
    end
  end
  always_comb begin
    active = h_cnt < 11'(H_ACTIVE) && v_cnt < 11'(V_ACTIVE);
    hs_n = !(h_cnt >= 11'(H_ACTIVE + H_FP) && h_cnt < 11'(H_ACTIVE + H_FP + H_SYNC));
    vs_n = !(v_cnt >= 11'(V_ACTIVE + V_FP) && v_cnt < 11'(V_ACTIVE + V_FP + V_SYNC));
  end
  // delay line keeps timing aligned with the drawers' DRAW_LATENCY-cycle pipeline
  always_ff @(posedge CLK) begin
    if (RESET) begin
      active_d <= '0;
      hs_d <= '1;
      vs_d <= '1;
    end else begin
      active_d <= DRAW_LATENCY'({active_d, active});
      hs_d <= DRAW_LATENCY'({hs_d, hs_n});
      vs_d <= DRAW_LATENCY'({vs_d, vs_n});
    end
  end
  always_comb color = !active_d[DRAW_LATENCY-1] ? 8'h00 : bus.drawing_request ? bus.mVGA_RGB : BG_COLOR;
  always_ff @(posedge CLK) begin
    if (RESET) begin
      bus.VGA_R <= '0;
      bus.VGA_G <= '0;
      bus.VGA_B <= '0;
      bus.VGA_HS <= 1'b1;
      bus.VGA_VS <= 1'b1;
      bus.VGA_BLANK_N <= 1'b0;
    end else begin
      bus.VGA_R <= {color[7:5], color[7:5], color[7:6]};
      bus.VGA_G <= {color[4:2], color[4:2], color[4:3]};
      bus.VGA_B <= {color[1:0], color[1:0], color[1:0], color[1:0]};
      bus.VGA_HS <= hs_d[DRAW_LATENCY-1];
      bus.VGA_VS <= vs_d[DRAW_LATENCY-1];
      bus.VGA_BLANK_N <= active_d[DRAW_LATENCY-1];
    end
  end
endmodule

// File: tb/tb_vga_pixel_requester.sv
// tb_vga_pixel_requester: randomized drawer traffic checked against a cycle-count raster model
module tb_vga_pixel_requester;
  localparam int HA = 20, HF = 3, HSW = 5, HB = 4;
  localparam int VA = 12, VF = 2, VSW = 2, VB = 3;
  localparam int HT = HA + HF + HSW + HB;
  localparam int VT = VA + VF + VSW + VB;
  localparam logic [7:0] BG = 8'h03;
  logic clk = 0;
  logic rst = 1;
  vga_pixel_requester_if vif();
  vga_pixel_requester #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HSW), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VSW), .V_BP(VB),
    .DRAW_LATENCY(1), .BG_COLOR(BG)
  ) dut (.CLK(clk), .RESET(rst), .bus(vif));
  always #5 clk = ~clk;
  int checks = 0, errors = 0;
  int n = 0, mh = 0, mv = 0, h1 = 0, v1 = 0, h2 = 0, v2 = 0;
  bit armed = 0, r1 = 0, r2 = 0, dr1 = 0;
  logic [7:0] rgb1 = 0;
  int hs_run = 0, vs_run = 0, bl_run = 0, fs_gap = -1;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (model h=%0d v=%0d)", name, act, exp, mh, mv);
    end
  endtask
  // 3-bit fields scale by 73/2 (0..7 -> 0..255), 2-bit by 85
  function automatic logic [23:0] expand(input logic [7:0] c);
    logic [8:0] r9, g9;
    r9 = c[7:5] * 9'd73;
    g9 = c[4:2] * 9'd73;
    return {r9[8:1], g9[8:1], c[1:0] * 8'h55};
  endfunction
  task automatic step();
    bit r0, act, ehs, evs, ebl;
    logic [23:0] rgb;
    r0 = rst;
    if (r1) begin n = 0; armed = 1; end else n++;
    mh = n % HT;
    mv = (n / HT) % VT;
    if (armed) begin
      chk("coord_x", vif.oCoord_X, mh);
      chk("coord_y", vif.oCoord_Y, mv);
      chk("frame_start", vif.frame_start, (n % (HT * VT) == 0 && !r0));
      if (r1 || r2) begin
        rgb = 0; ehs = 1; evs = 1; ebl = 0;
      end else begin
        act = h2 < HA && v2 < VA;
        rgb = expand(!act ? 8'h00 : dr1 ? rgb1 : BG);
        ehs = !(h2 >= HA + HF && h2 < HA + HF + HSW);
        evs = !(v2 >= VA + VF && v2 < VA + VF + VSW);
        ebl = act;
      end
      chk("vga_r", vif.VGA_R, rgb[23:16]);
      chk("vga_g", vif.VGA_G, rgb[15:8]);
      chk("vga_b", vif.VGA_B, rgb[7:0]);
      chk("vga_hs", vif.VGA_HS, ehs);
      chk("vga_vs", vif.VGA_VS, evs);
      chk("blank_n", vif.VGA_BLANK_N, ebl);
      if (r0 || r1 || r2) begin
        hs_run = 0; vs_run = 0; bl_run = 0; fs_gap = -1;
      end else begin
        if (vif.VGA_HS === 1'b0) hs_run++;
        else begin if (hs_run > 0) chk("hs_width", hs_run, HSW); hs_run = 0; end
        if (vif.VGA_VS === 1'b0) vs_run++;
        else begin if (vs_run > 0) chk("vs_width", vs_run, VSW * HT); vs_run = 0; end
        if (vif.VGA_BLANK_N === 1'b1) bl_run++;
        else begin if (bl_run > 0) chk("blank_width", bl_run, HA); bl_run = 0; end
        if (fs_gap >= 0) fs_gap++;
        if (vif.frame_start === 1'b1) begin
          if (fs_gap > 0) chk("frame_period", fs_gap, HT * VT);
          fs_gap = 0;
        end
      end
    end
    h2 = h1; v2 = v1; h1 = mh; v1 = mv;
    dr1 = vif.drawing_request; rgb1 = vif.mVGA_RGB;
    r2 = r1; r1 = r0;
  endtask
  task automatic tick(input bit r, input bit d, input logic [7:0] c);
    @(posedge clk);
    #1;
    rst = r;
    vif.drawing_request = d;
    vif.mVGA_RGB = c;
    @(negedge clk);
    step();
  endtask
  task automatic wait_at(input int h, input int v);
    int k;
    for (k = 0; k < 2 * HT * VT && !(mh == h && mv == v); k++) tick(0, 1'($urandom), 8'($urandom));
    if (!(mh == h && mv == v)) begin
      checks++; errors++;
      $display("FAIL wait_timeout: never reached (%0d,%0d)", h, v);
    end
  endtask
  initial begin
    vif.drawing_request = 0;
    vif.mVGA_RGB = 0;
    repeat (3) tick(1, 0, 8'h00);
    chk("reset_fs", vif.frame_start, 0);
    chk("reset_hs", vif.VGA_HS, 1);
    tick(0, 0, 8'h00);
    chk("rel_x", vif.oCoord_X, 0);
    chk("rel_fs", vif.frame_start, 1);
    chk("rel_blank0", vif.VGA_BLANK_N, 0);
    tick(0, 0, 8'h00);
    chk("rel_blank1", vif.VGA_BLANK_N, 0);
    tick(0, 0, 8'h00);
    chk("rel_blank2", vif.VGA_BLANK_N, 1);
    chk("bg_b", vif.VGA_B, 8'hFF);
    chk("bg_r", vif.VGA_R, 8'h00);
    wait_at(10, 5);
    tick(0, 1, 8'h54);
    tick(0, 1, 8'hE0);
    chk("c54_r", vif.VGA_R, 8'h49);
    chk("c54_g", vif.VGA_G, 8'hB6);
    chk("c54_b", vif.VGA_B, 8'h00);
    tick(0, 0, 8'h00);
    chk("cE0_r", vif.VGA_R, 8'hFF);
    chk("cE0_g", vif.VGA_G, 8'h00);
    wait_at(24, 5);
    tick(0, 1, 8'hFF);
    tick(0, 0, 8'h00);
    chk("blanked_r", vif.VGA_R, 8'h00);
    chk("blanked_n", vif.VGA_BLANK_N, 0);
    wait_at(14, 7);
    tick(1, 1, 8'hFF);
    tick(0, 1, 8'hFF);
    chk("mid_x", vif.oCoord_X, 0);
    chk("mid_y", vif.oCoord_Y, 0);
    chk("mid_fs", vif.frame_start, 1);
    chk("mid_hs", vif.VGA_HS, 1);
    chk("mid_blank", vif.VGA_BLANK_N, 0);
    for (int i = 0; i < 20000; i++) tick($urandom_range(2999) == 0, 1'($urandom), 8'($urandom));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/vga_pixel_requester.md
Name: vga_pixel_requester

Overview:
- Owns the VGA 640x480@60 raster timing. Runs on the 25 MHz pixel clock.
- Each cycle it issues the current pixel coordinate (oCoord_X/oCoord_Y) to the sprite drawers.
- It accepts the resulting colour/request pair one clock later, substituting a background colour where nothing draws.
- It drives the DAC-side RGB, sync and blank pins, with syncs delayed to stay pixel-aligned with the drawer pipeline.

Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch
- H_SYNC, 96, horizontal sync width
- H_BP, 48, horizontal back porch
- V_ACTIVE, 480, visible lines
- V_FP, 10, vertical front porch
- V_SYNC, 2, vertical sync width
- V_BP, 33, vertical back porch
- DRAW_LATENCY, 1, clocks from oCoord change to matching mVGA_RGB/drawing_request
- BG_COLOR, 8'h00, RRRGGGBB colour used when drawing_request=0

Ports:
- CLK  in  1  pixel clock
- RESET  in  1  synchronous, active-high reset
- oCoord_X  out  11  current horizontal counter, 0..H_TOTAL-1
- oCoord_Y  out  11  current vertical counter, 0..V_TOTAL-1
- frame_start  out  1  high for the single cycle in which counters=(0,0) and RESET=0
- drawing_request  in  1  drawer request, DRAW_LATENCY after oCoord
- mVGA_RGB  in  8  drawer colour RRRGGGBB, same timing as drawing_request
- VGA_R  out  8  red
- VGA_G  out  8  green
- VGA_B  out  8  blue
- VGA_HS  out  1  hsync, active low
- VGA_VS  out  1  vsync, active low
- VGA_BLANK_N  out  1  high in the visible area

Behaviour:
- Interface: one clock (CLK); reset RESET is synchronous and active-high.
- Totals: H_TOTAL=H_ACTIVE+H_FP+H_SYNC+H_BP (800); V_TOTAL likewise (525).
- Counters:
  - h_cnt increments every cycle and wraps H_TOTAL-1 -> 0.
  - v_cnt increments only when h_cnt wraps, and wraps V_TOTAL-1 -> 0.
  - oCoord_X/oCoord_Y are the counter registers themselves.
  - Counters keep counting through the blanking regions; no saturation.
- Raw (cycle t) signals, computed from counters:
  - active = h<H_ACTIVE && v<V_ACTIVE.
  - hs_n low for H_ACTIVE+H_FP <= h < H_ACTIVE+H_FP+H_SYNC (656..751).
  - vs_n low for 490..491, the same formula vertically.
- Alignment: active, hs_n and vs_n pass through a DRAW_LATENCY-deep shift register, then meet the drawer inputs.
- Output register: on each cycle, using the delayed active:
  - delayed active=0: RGB=0.
  - delayed active=1 and drawing_request=1: colour=mVGA_RGB.
  - delayed active=1 and drawing_request=0: colour=BG_COLOR.
- Latency: pin outputs for counter value (h,v) at cycle t appear at cycle t+DRAW_LATENCY+1. HS, VS, BLANK_N and RGB are all registered in the same stage.
- Colour expansion of c=RRRGGGBB:
  - VGA_R = {c[7:5],c[7:5],c[7:6]}
  - VGA_G = {c[4:2],c[4:2],c[4:3]}
  - VGA_B = {c[1:0],c[1:0],c[1:0],c[1:0]}
- Reset, including mid-frame:
  - Counters go to 0 and all delay stages clear to inactive values (active=0, hs_n=1, vs_n=1).
  - Outputs reset to VGA_R/G/B=0, VGA_HS=1, VGA_VS=1, VGA_BLANK_N=0.
  - frame_start=0 while RESET=1.
  - The first cycle after RESET falls shows counters (0,0) with frame_start=1.
- Simultaneous wrap: at (799,524) the next cycle is (0,0) and frame_start pulses. There is no extra cycle and no skipped line.
- Inputs are ignored outside the delayed active window; drawers may assert drawing_request anywhere without effect there.

Test Plan:
- Reset, then release -> frame_start=1 on the first cycle with oCoord=(0,0); VGA_HS=1, VGA_VS=1, VGA_BLANK_N=0 until the pipeline fills; BLANK_N rises at cycle 2 after release.
- Free-run one line -> VGA_HS low for exactly 96 cycles, its first low cycle 2 cycles after oCoord_X=656; VGA_BLANK_N high for 640 consecutive cycles per visible line.
- Free-run a full frame -> 420000 cycles between frame_start pulses; VGA_VS low for 2 lines (1600 cycles) starting 2 cycles after oCoord_Y=490,X=0.
- Drive drawing_request=1, mVGA_RGB=8'h54 one cycle after oCoord=(10,5) -> the next cycle shows VGA_R=8'h49, VGA_G=8'hB6, VGA_B=8'h00; with mVGA_RGB=8'hE0 the pins show R=FF, G=00, B=00.
- drawing_request=0 in the visible area with BG_COLOR=8'h03 -> B=FF, R=G=00; drawing_request=1 at oCoord_X=700 -> RGB=0, blanked.
- Assert RESET at oCoord=(300,200) for 1 cycle -> the next cycle shows oCoord=(0,0) and outputs at reset values; timing then repeats exactly as after power-up.
